// File: rtl/reg_adj_pkg.sv
// Shared types and helpers for the multi-channel plus/minus register adjuster.
package reg_adj_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } fsm_state_e;

  typedef enum logic [1:0] {
    DirNone,
    DirUp,
    DirDown
  } dir_e;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hold_repeat_fsm.sv
// Press/hold/auto-repeat timing: emits a one-cycle step at the press edge, after
// HOLD_DELAY cycles, then every REPEAT_PERIOD cycles while the same press persists.
module hold_repeat_fsm
  import reg_adj_pkg::*;
#(
  parameter int unsigned SEL_W         = 2,
  parameter int unsigned HOLD_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  dir_e             dir_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             step_o,
  output dir_e             step_dir_o
);

  localparam int unsigned MaxCount =
    (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned TimerW = clog2_min1(MaxCount);
  localparam logic [TimerW-1:0] HoldLoad   = TimerW'(HOLD_DELAY - 1);
  localparam logic [TimerW-1:0] RepeatLoad = TimerW'(REPEAT_PERIOD - 1);

  fsm_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  dir_e              dir_q, dir_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  // Next state, countdown and step pulse; dir/sel are latched at press start.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dir_d      = dir_q;
    sel_d      = sel_q;
    step_o     = 1'b0;
    step_dir_o = dir_i;
    unique case (state_q)
      StIdle: begin
        if (dir_i != DirNone) begin
          step_o  = 1'b1;
          timer_d = HoldLoad;
          dir_d   = dir_i;
          sel_d   = sel_i;
          state_d = StHold;
        end
      end
      StHold, StRepeat: begin
        // Release or any change of the press aborts without stepping.
        if (dir_i == DirNone || dir_i != dir_q || sel_i != sel_q) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == '0) begin
          step_o  = 1'b1;
          timer_d = RepeatLoad;
          state_d = StRepeat;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and latched press registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      dir_q   <= DirNone;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: rtl/multi_reg_adjuster.sv
// Bank of NUM_CH bounded registers; the channel addressed by sel is stepped from
// plus/minus button levels (with hold auto-repeat) or loaded directly.
module multi_reg_adjuster
  import reg_adj_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 16,
  parameter int unsigned RESET_VAL     = 0,
  parameter int unsigned STEP          = 1,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned HOLD_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD = 4,
  localparam int unsigned SEL_W        = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    minus,
  input  logic                    plus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_value,
  output logic [NUM_CH*WIDTH-1:0] values,
  output logic                    changed,
  output logic                    at_min,
  output logic                    at_max
);

  localparam logic [WIDTH-1:0] MinV  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxV  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RstV  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] StepV = WIDTH'(STEP);
  localparam logic [WIDTH:0]   MinW  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MaxW  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   StepW = (WIDTH+1)'(STEP);
  localparam bit               DoWrap = (WRAP != 0);

  logic [NUM_CH-1:0][WIDTH-1:0] vals_q, vals_d;
  logic                         changed_q, changed_d;

  dir_e             dir;
  logic             step;
  dir_e             step_dir;
  logic             sel_ok;
  logic [SEL_W-1:0] sel_idx;
  logic [WIDTH-1:0] cur_val, up_val, down_val, load_clamped;
  logic [WIDTH:0]   sum;

  // Button levels to direction; both pressed counts as no press.
  always_comb begin
    dir = DirNone;
    if (plus && !minus) begin
      dir = DirUp;
    end else if (minus && !plus) begin
      dir = DirDown;
    end
  end

  hold_repeat_fsm #(
    .SEL_W        (SEL_W),
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .dir_i     (dir),
    .sel_i     (sel),
    .step_o    (step),
    .step_dir_o(step_dir)
  );

  // Candidate values for the selected channel: stepped up/down and clamped load.
  always_comb begin
    sel_ok  = (32'(sel) < NUM_CH);
    sel_idx = sel_ok ? sel : '0;
    cur_val = vals_q[sel_idx];

    sum = {1'b0, cur_val} + StepW;
    if (sum > MaxW) begin
      up_val = DoWrap ? MinV : MaxV;
    end else begin
      up_val = sum[WIDTH-1:0];
    end

    if ({1'b0, cur_val} < MinW + StepW) begin
      down_val = DoWrap ? MaxV : MinV;
    end else begin
      down_val = cur_val - StepV;
    end

    if (load_value < MinV) begin
      load_clamped = MinV;
    end else if (load_value > MaxV) begin
      load_clamped = MaxV;
    end else begin
      load_clamped = load_value;
    end
  end

  // Register file update; load wins over a coincident step.
  always_comb begin
    vals_d = vals_q;
    if (sel_ok) begin
      if (load) begin
        vals_d[sel_idx] = load_clamped;
      end else if (step) begin
        vals_d[sel_idx] = (step_dir == DirUp) ? up_val : down_val;
      end
    end
    changed_d = (vals_d != vals_q);
  end

  // Register bank and change flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      vals_q    <= {NUM_CH{RstV}};
      changed_q <= 1'b0;
    end else begin
      vals_q    <= vals_d;
      changed_q <= changed_d;
    end
  end

  assign values  = vals_q;
  assign changed = changed_q;
  assign at_min  = sel_ok && (cur_val == MinV);
  assign at_max  = sel_ok && (cur_val == MaxV);

endmodule

// File: tb/tb_multi_reg_adjuster.sv
// Drives four differently parameterised adjusters with the same stimulus and
// compares them every cycle against a press-age based reference model.
module tb_multi_reg_adjuster;

  localparam int unsigned HOLD = 8;
  localparam int unsigned RP   = 4;

  logic       clk = 1'b0;
  logic       reset, plus, minus, load;
  logic [1:0] sel;
  logic [7:0] load_value;

  logic [31:0] values_0, values_1, values_2;
  logic [23:0] values_3;
  logic        chg [4];
  logic        amin[4];
  logic        amax[4];

  // Instance settings: default, step 3, wrap, odd (3 ch, 2..20, reset 5, step 2, wrap).
  int nch[4] = '{4, 4, 4, 3};
  int mn [4] = '{0, 0, 0, 2};
  int mx [4] = '{16, 16, 16, 20};
  int rv [4] = '{0, 0, 0, 5};
  int st [4] = '{1, 3, 1, 2};
  int wr [4] = '{0, 0, 1, 1};

  int mv[4][4];
  int exp_chg[4];
  bit active;
  int age, pdir;
  logic [1:0] psel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_reg_adjuster u_def (
    .clk(clk), .reset(reset), .minus(minus), .plus(plus), .sel(sel), .load(load),
    .load_value(load_value), .values(values_0), .changed(chg[0]), .at_min(amin[0]),
    .at_max(amax[0])
  );

  multi_reg_adjuster #(.STEP(3)) u_sat (
    .clk(clk), .reset(reset), .minus(minus), .plus(plus), .sel(sel), .load(load),
    .load_value(load_value), .values(values_1), .changed(chg[1]), .at_min(amin[1]),
    .at_max(amax[1])
  );

  multi_reg_adjuster #(.WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .minus(minus), .plus(plus), .sel(sel), .load(load),
    .load_value(load_value), .values(values_2), .changed(chg[2]), .at_min(amin[2]),
    .at_max(amax[2])
  );

  multi_reg_adjuster #(
    .NUM_CH(3), .MIN_VAL(2), .MAX_VAL(20), .RESET_VAL(5), .STEP(2), .WRAP(1)
  ) u_odd (
    .clk(clk), .reset(reset), .minus(minus), .plus(plus), .sel(sel), .load(load),
    .load_value(load_value), .values(values_3), .changed(chg[3]), .at_min(amin[3]),
    .at_max(amax[3])
  );

  function automatic logic [7:0] obs_val(int k, int c);
    case (k)
      0:       return values_0[c*8 +: 8];
      1:       return values_1[c*8 +: 8];
      2:       return values_2[c*8 +: 8];
      default: return values_3[c*8 +: 8];
    endcase
  endfunction

  // Reference: a press steps at age 0, at age HOLD, then every RP cycles.
  task automatic model_edge();
    int  d, nv;
    bit  stp;
    d = (plus && !minus) ? 1 : ((minus && !plus) ? 2 : 0);
    if (reset) begin
      active = 0;
      for (int k = 0; k < 4; k++) begin
        exp_chg[k] = 0;
        for (int c = 0; c < 4; c++) mv[k][c] = rv[k];
      end
      return;
    end
    stp = 0;
    if (!active) begin
      if (d != 0) begin
        stp = 1; active = 1; age = 0; pdir = d; psel = sel;
      end
    end else if (d == 0 || d != pdir || sel != psel) begin
      active = 0;
    end else begin
      age++;
      stp = (age >= HOLD) && (((age - HOLD) % RP) == 0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_chg[k] = 0;
      if (int'(sel) < nch[k]) begin
        nv = mv[k][sel];
        if (load) begin
          nv = int'(load_value);
          if (nv < mn[k]) nv = mn[k];
          if (nv > mx[k]) nv = mx[k];
        end else if (stp && d == 1) begin
          nv = nv + st[k];
          if (nv > mx[k]) nv = wr[k] ? mn[k] : mx[k];
        end else if (stp && d == 2) begin
          if (nv < mn[k] + st[k]) nv = wr[k] ? mx[k] : mn[k];
          else nv = nv - st[k];
        end
        exp_chg[k] = (nv != mv[k][sel]) ? 1 : 0;
        mv[k][sel] = nv;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] o;
    bit em, ex;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < nch[k]; c++) begin
        o = obs_val(k, c);
        checks++;
        assert (o === 8'(mv[k][c])) else begin
          errors++;
          $error("FAIL value u%0d ch%0d got %0d expected %0d", k, c, o, mv[k][c]);
        end
      end
      checks++;
      assert (chg[k] === 1'(exp_chg[k])) else begin
        errors++;
        $error("FAIL changed u%0d got %b expected %0d", k, chg[k], exp_chg[k]);
      end
      em = (int'(sel) < nch[k]) && (mv[k][sel] == mn[k]);
      ex = (int'(sel) < nch[k]) && (mv[k][sel] == mx[k]);
      checks++;
      assert (amin[k] === em) else begin
        errors++;
        $error("FAIL at_min u%0d got %b expected %b", k, amin[k], em);
      end
      checks++;
      assert (amax[k] === ex) else begin
        errors++;
        $error("FAIL at_max u%0d got %b expected %b", k, amax[k], ex);
      end
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; plus = 0; minus = 0; load = 0; sel = 0; load_value = 0;
    cycle();
    cycle();
    reset = 0;
    cycle();
    check_const("reset_def_values", values_0, 32'd0);
    check_const("reset_odd_values", {8'd0, values_3}, {8'd0, 8'd5, 8'd5, 8'd5});

    // Single press on ch0.
    sel = 0; plus = 1;
    cycle();
    check_const("press_ch0", values_0, 32'h0000_0001);
    check_const("press_changed", chg[0], 1);
    plus = 0;
    cycle();
    check_const("press_changed_drop", chg[0], 0);

    // Auto-repeat: 20 held cycles give steps at 0, 8, 12, 16.
    sel = 2; plus = 1;
    repeat (20) cycle();
    plus = 0;
    cycle();
    check_const("repeat_ch2", values_0[23:16], 4);

    // Saturation with STEP=3.
    sel = 1; load = 1; load_value = 15;
    cycle();
    load = 0;
    plus = 1;
    cycle();
    check_const("sat_first", values_1[15:8], 16);
    check_const("sat_first_chg", chg[1], 1);
    plus = 0;
    cycle();
    plus = 1;
    cycle();
    check_const("sat_second", values_1[15:8], 16);
    check_const("sat_second_chg", chg[1], 0);
    check_const("sat_at_max", amax[1], 1);
    plus = 0;
    cycle();

    // Wrap at both limits.
    sel = 0; load = 1; load_value = 16;
    cycle();
    load = 0; plus = 1;
    cycle();
    check_const("wrap_up", values_2[7:0], 0);
    plus = 0;
    cycle();
    minus = 1;
    cycle();
    check_const("wrap_down", values_2[7:0], 16);
    minus = 0;
    cycle();

    // Both buttons held: nothing moves.
    plus = 1; minus = 1;
    repeat (10) begin
      cycle();
      check_const("both_no_change", chg[0], 0);
    end
    plus = 0; minus = 0;
    cycle();

    // Sel change mid-press aborts, then a fresh press starts on the new channel.
    load = 1; load_value = 5;
    cycle();
    load = 0; plus = 1;
    repeat (5) cycle();
    check_const("selchg_ch0", values_0[7:0], 6);
    sel = 3;
    cycle();
    check_const("selchg_abort", values_0[31:24], 0);
    cycle();
    check_const("selchg_fresh", values_0[31:24], 1);
    plus = 0;
    cycle();

    // Load beats a coincident step and is clamped.
    sel = 1; plus = 1; load = 1; load_value = 200;
    cycle();
    check_const("load_clamp_def", values_0[15:8], 16);
    check_const("load_no_step_odd", values_3[15:8], 20);
    load = 0;
    sel = 0;
    cycle();
    repeat (14) cycle();
    reset = 1;
    cycle();
    check_const("reset_mid_repeat", values_0, 32'd0);
    reset = 0;
    cycle();
    check_const("reset_fsm_idle", values_0[7:0], 1);

    // Randomised long presses with occasional sel changes, loads and resets.
    repeat (600) begin
      if ($urandom_range(15) == 0) begin
        plus  = 1'($urandom_range(1));
        minus = 1'($urandom_range(1));
      end
      if ($urandom_range(31) == 0) sel = 2'($urandom_range(3));
      load       = ($urandom_range(19) == 0);
      load_value = ($urandom_range(1) != 0) ? 8'($urandom_range(24)) : 8'($urandom_range(255));
      reset      = ($urandom_range(199) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_reg_adjuster.md
Name: multi_reg_adjuster

Overview:
- Parametrised successor of the single-register plus/minus controller.
- Holds NUM_CH independent bounded registers and adjusts the one addressed by `sel` from plus/minus button levels.
- Adds configurable step, saturate-or-wrap limit mode, hold-to-auto-repeat, direct load and status flags.
- Sits between the button conditioning logic and display/setting consumers; buttons arrive already debounced and synchronous to clk.

Parameters:
- WIDTH, 8, bit width of each register.
- NUM_CH, 4, number of registers (1..16).
- MIN_VAL, 0, lower limit.
- MAX_VAL, 16, upper limit; MIN_VAL < MAX_VAL < 2**WIDTH.
- RESET_VAL, 0, value of every register after reset; must lie within [MIN_VAL, MAX_VAL].
- STEP, 1, increment/decrement amount; 1 <= STEP <= MAX_VAL-MIN_VAL.
- WRAP, 0, 0 = saturate at limits, 1 = wrap past a limit to the opposite limit.
- HOLD_DELAY, 8, cycles from the first step to the first auto-repeat step (>= 2).
- REPEAT_PERIOD, 4, cycles between auto-repeat steps (>= 1).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- minus  in  1  decrement button level
- plus  in  1  increment button level
- sel  in  max(1,clog2(NUM_CH))  channel selected for stepping; values >= NUM_CH are ignored (no step)
- load  in  1  write load_value into channel sel this cycle
- load_value  in  WIDTH  data for load
- values  out  NUM_CH*WIDTH  all registers; channel i occupies bits [i*WIDTH +: WIDTH]
- changed  out  1  registered pulse, high one cycle after any register value actually changed
- at_min  out  1  selected channel == MIN_VAL (combinational from registers and sel)
- at_max  out  1  selected channel == MAX_VAL

Behaviour:
- Reset:
  - All channels = RESET_VAL.
  - FSM enters IDLE; timer = 0; changed = 0.
  - Reset overrides every other input in the same cycle.
- Direction:
  - dir = UP when plus & ~minus; DOWN when minus & ~plus.
  - NONE otherwise; both pressed counts as NONE.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE: dir != NONE → issue step, load timer with HOLD_DELAY-1, go to HOLD.
  - HOLD: dir == NONE → IDLE. Otherwise decrement timer; when timer == 0, issue step, load timer with REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: dir == NONE → IDLE. Otherwise count down; at 0 issue step and reload REPEAT_PERIOD-1.
  - In HOLD/REPEAT, a change of dir or sel from the value latched at press start → IDLE with no step. The new press is recognised on the following cycle.
- Step timing: pulses at press edge k, then k+HOLD_DELAY, then every REPEAT_PERIOD cycles. The register updates at the step edge and is visible on `values` after it.
- Arithmetic: computed in WIDTH+1 bits.
  - UP, WRAP=0: value+STEP > MAX_VAL → MAX_VAL.
  - DOWN, WRAP=0: value < MIN_VAL+STEP → MIN_VAL.
  - WRAP=1: any step that would exceed MAX_VAL yields MIN_VAL, and any step below MIN_VAL yields MAX_VAL (no modular remainder).
- Load:
  - Priority over a step in the same cycle; that step is discarded and the FSM still advances.
  - load_value is clamped into [MIN_VAL, MAX_VAL].
  - Load with sel >= NUM_CH is ignored.
- changed: asserted only if the new value differs from the old one. Saturated steps at a limit do not pulse.
- Unselected channels never change.

Decomposition:
- Package `reg_adj_pkg`:
  - FSM state enum (IDLE, HOLD, REPEAT).
  - dir encoding (NONE, UP, DOWN).
  - clog2-based width function for sel and timer.
- Sub-module `hold_repeat_fsm`:
  - Inputs: clk, reset, dir, sel.
  - Output: step pulse plus step direction.
  - Parameters: HOLD_DELAY, REPEAT_PERIOD.
  - Keeps timing separate from the register file and clamp arithmetic in the top level.

Test Plan (defaults unless stated):
- Reset: reset, then hold plus on ch0 for 1 cycle → values ch0 = 1, changed pulses once; all other channels stay 0.
- Auto-repeat: hold plus on ch2 for 20 cycles → steps at cycles 0, 8, 12, 16; ch2 = 4.
- Saturation at MAX: ch1 loaded with 15, STEP=3, press plus twice (separate presses) → 16 then 16; at_max = 1; changed pulses only on the first press.
- Wrap at both limits: WRAP=1, ch0 = 16, press plus → 0; press minus → 16.
- Both buttons and sel change: plus and minus together for 10 cycles → no change, FSM stays IDLE. While holding plus, change sel 0→3 at cycle 5 → one step on ch0, no step that cycle, then a fresh press on ch3 next cycle.
- Load: load=1, load_value=200, sel=1 with plus asserted → ch1 = 16 (clamped), no extra increment. Reset mid-repeat → all channels 0 next cycle, FSM in IDLE.
